// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run supervisor for the multicycle core (start gating, counting, halt/timeout, writeback signature).
// Define MEM_SIG_EN to also fold data-memory writes into the signature.
module cpu_run_monitor #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = 3,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              running,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic [ADDR_W-1:0] last_pc,
    output logic [DATA_W-1:0] wb_signature
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d, rep_q, rep_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] sig_q, sig_d, reg_term, mem_term;
    logic              sig_en;
    logic              running_q, halted_q, timeout_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    assign reg_term = regwrite ? (reg_wdata ^ DATA_W'(reg_waddr)) : '0;

`ifdef MEM_SIG_EN
    assign mem_term = memwrite ? (mem_addr ^ rotl1(mem_wdata)) : '0;
    assign sig_en   = regwrite | memwrite;
`else
    logic unused_mem;
    assign unused_mem = ^{memwrite, mem_addr, mem_wdata};
    assign mem_term   = '0;
    assign sig_en     = regwrite;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        rep_d   = rep_q;
        pc_d    = pc_q;
        sig_d   = sig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    ins_d   = '0;
                    rep_d   = '0;
                    pc_d    = '0;
                    sig_d   = '0;
                end
            end
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                // Repeat tracking only advances on real fetches, since the core idles between them.
                if (fetch_valid) begin
                    ins_d = sat_inc(ins_q);
                    pc_d  = pc;
                    rep_d = (pc == pc_q && ins_q != '0) ? sat_inc(rep_q) : CNT_W'(1);
                end
                if (sig_en) sig_d = rotl1(sig_q) ^ reg_term ^ mem_term;
                if (fetch_valid && rep_d == CNT_W'(HALT_REPEAT))
                    state_d = HALTED;
                else if (cyc_q == CNT_W'(MAX_CYCLES - 1))
                    state_d = TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            ins_q     <= '0;
            rep_q     <= '0;
            pc_q      <= '0;
            sig_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            rep_q     <= rep_d;
            pc_q      <= pc_d;
            sig_q     <= sig_d;
            running_q <= state_d == RUN;
            halted_q  <= state_d == HALTED;
            timeout_q <= state_d == TIMEOUT;
        end
    end

    assign running      = running_q;
    assign halted       = halted_q;
    assign timeout      = timeout_q;
    assign done         = halted_q | timeout_q;
    assign cycle_count  = cyc_q;
    assign instr_count  = ins_q;
    assign last_pc      = pc_q;
    assign wb_signature = sig_q;
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Parametrised run controller and observer for the multicycle RISC core.
- Replaces fixed-delay simulation stop with cycle-accurate run supervision: start gating, retired-instruction and cycle counting, halt detection, timeout, and a register-writeback signature for self-checking benches.
- Sits beside multi_cycle and taps its fetch, register-write and memory-write strobes.
- Result outputs (done/halted/timeout/counts/signature) are sampled by a bench or debug logic.

Parameters:
- DATA_W, 16, datapath/register width.
- ADDR_W, 16, PC width.
- REG_AW, 3, register index width.
- CNT_W, 32, width of cycle/instruction counters.
- MAX_CYCLES, 1000, run cycles before timeout; must be >= 2.
- HALT_REPEAT, 3, consecutive fetches of the same PC that mean halt; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- fetch_valid  in  1  core is in fetch state this cycle.
- pc  in  ADDR_W  PC of current fetch.
- regwrite  in  1  register-file write strobe.
- reg_waddr  in  REG_AW  written register index.
- reg_wdata  in  DATA_W  written data.
- memwrite  in  1  data-memory write strobe.
- mem_addr  in  DATA_W  memory write address.
- mem_wdata  in  DATA_W  memory write data.
- running  out  1  high in RUN.
- done  out  1  high in HALTED or TIMEOUT.
- halted  out  1  high in HALTED.
- timeout  out  1  high in TIMEOUT.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instr_count  out  CNT_W  fetches observed in RUN.
- last_pc  out  ADDR_W  PC of most recent fetch in RUN.
- wb_signature  out  DATA_W  writeback signature.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, internal repeat counter 0.
- States: IDLE, RUN, HALTED, TIMEOUT. All outputs are registered.
- IDLE: inputs other than start are ignored. On start: -> RUN; counters, signature, last_pc and repeat count are cleared on the same edge.
- RUN, each clock:
  - cycle_count += 1.
  - If fetch_valid: instr_count += 1 and last_pc <= pc.
  - Repeat counter: if pc == last_pc and instr_count != 0, rep += 1; otherwise rep <= 1.
  - Halt: if fetch_valid and the updated rep == HALT_REPEAT -> HALTED.
  - Timeout: else if cycle_count == MAX_CYCLES-1 -> TIMEOUT. Halt wins on a simultaneous event.
  - If regwrite: wb_signature <= rotl1(wb_signature) ^ reg_wdata ^ zext(reg_waddr).
  - A regwrite or fetch in the terminating cycle is still counted and folded in.
- HALTED / TIMEOUT: all outputs frozen; start is ignored. Only reset leaves these states.
- start while already in RUN: ignored; no restart.
- Counters saturate at all-ones; they never wrap.
- reset during RUN clears everything immediately; the next run requires a new start.
- memwrite/mem_addr/mem_wdata have no effect unless MEM_SIG_EN is defined.

Optional Feature:
- Macro: MEM_SIG_EN.
- Defined: on each memwrite in RUN, the signature additionally folds in mem_addr ^ rotl1(mem_wdata).
  - Applied after the register term in the same cycle: sig <= rotl1(sig) ^ regterm ^ memterm, where regterm is 0 if regwrite is low.
  - A memwrite-only cycle still rotates the signature.
- Undefined: memory ports are unused; the signature covers register writes only.

Test Plan:
- Reset: assert reset mid-RUN at cycle 5 -> all outputs 0 asynchronously, state IDLE; fetch_valid pulses with no start -> instr_count stays 0.
- Signature: start, then regwrite r1=0x0005, then r4=0x000A (MEM_SIG_EN off) -> wb_signature 0x0004, then 0x0006.
- Halt: with HALT_REPEAT=3, fetch PCs 0,1,2,2,2 -> halted=1 on the edge of the 5th fetch; instr_count=5, last_pc=2; outputs stable for 20 further cycles.
- Timeout: MAX_CYCLES=8, fetches with distinct PCs -> timeout=1 with cycle_count=8; a later start pulse is ignored.
- Halt/timeout collision: MAX_CYCLES=6, third repeat fetch in the 6th RUN cycle -> halted=1, timeout=0.
- MEM_SIG_EN: start, memwrite addr=0x0010 data=0x0003, no regwrite -> wb_signature=0x0016; with the macro undefined -> 0x0000.
